// File: rtl/dcache_dm_if.sv
// rtl/dcache_dm_if.sv - Signal bundle between dcache_dm, its requester (SLB) and the memory controller (MC)
// Signals:
//   rdy                    global enable
//   iMC_wait/done/dt       memory controller status and read data
//   oMC_en/ls/pc/dt/len    memory controller request
//   oSLB_en                cache can take a new request
//   iSLB_en/ls/pc/dt/len/nick  requester command
//   iInv                   invalidate all lines
//   oSLB_done/dt/nick      completion back to the requester
// Modports: slave is the cache view, master is the surrounding system view.
interface dcache_dm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 3,
  parameter int NICK_W = 4,
  parameter int WAIT_W = 2
);
  logic              rdy;
  logic [WAIT_W-1:0] iMC_wait;
  logic              iMC_done;
  logic [DATA_W-1:0] iMC_dt;
  logic              oMC_en;
  logic              oMC_ls;
  logic [ADDR_W-1:0] oMC_pc;
  logic [DATA_W-1:0] oMC_dt;
  logic [LEN_W-1:0]  oMC_len;
  logic              oSLB_en;
  logic              iSLB_en;
  logic              iSLB_ls;
  logic [ADDR_W-1:0] iSLB_pc;
  logic [DATA_W-1:0] iSLB_dt;
  logic [LEN_W-1:0]  iSLB_len;
  logic [NICK_W-1:0] iSLB_nick;
  logic              iInv;
  logic              oSLB_done;
  logic [DATA_W-1:0] oSLB_dt;
  logic [NICK_W-1:0] oSLB_nick;

  modport slave (
    input  rdy, iMC_wait, iMC_done, iMC_dt,
    input  iSLB_en, iSLB_ls, iSLB_pc, iSLB_dt, iSLB_len, iSLB_nick, iInv,
    output oMC_en, oMC_ls, oMC_pc, oMC_dt, oMC_len,
    output oSLB_en, oSLB_done, oSLB_dt, oSLB_nick
  );

  modport master (
    output rdy, iMC_wait, iMC_done, iMC_dt,
    output iSLB_en, iSLB_ls, iSLB_pc, iSLB_dt, iSLB_len, iSLB_nick, iInv,
    input  oMC_en, oMC_ls, oMC_pc, oMC_dt, oMC_len,
    input  oSLB_en, oSLB_done, oSLB_dt, oSLB_nick
  );
endinterface

// File: rtl/dcache_dm.sv
// rtl/dcache_dm.sv - Direct-mapped, write-through, no-write-allocate data cache with one outstanding request
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   dcache_dm_if.slave: requester command/response, memory controller request/response,
//         rdy global enable, iInv invalidate-all
// Load hits answer one cycle after acceptance; load misses, uncacheable loads and all stores
// go to the memory controller and answer one cycle after iMC_done.
module dcache_dm #(
  parameter int                ADDR_W  = 32,
  parameter int                DATA_W  = 32,
  parameter int                LEN_W   = 3,
  parameter int                NICK_W  = 4,
  parameter int                WAIT_W  = 2,
  parameter int                LINES   = 16,
  parameter logic [ADDR_W-1:0] IO_BASE = 32'h30000
) (
  input logic        clk,
  input logic        rst,
  dcache_dm_if.slave bus
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state_q, state_d;

  logic [DATA_W-1:0] data_q [LINES];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINES-1:0]  valid_q;

  logic              mc_en_q;
  logic              mc_ls_q;
  logic [ADDR_W-1:0] mc_pc_q;
  logic [DATA_W-1:0] mc_dt_q;
  logic [LEN_W-1:0]  mc_len_q;
  logic              done_q;
  logic [DATA_W-1:0] slb_dt_q;
  logic [NICK_W-1:0] slb_nick_q;
  logic [NICK_W-1:0] nick_q;
  logic              fill_q;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [1:0]        req_off;
  logic [DATA_W-1:0] line;
  logic              cacheable;
  logic              hit;
  logic              accept;
  logic              go_resp;
  logic              go_mc;
  logic              mc_finish;
  logic              fill_we;
  logic              store_we;
  logic [IDX_W-1:0]  fill_idx;
  logic [3:0]        len_be;
  logic [3:0]        wr_be;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] wr_shift;
  logic [DATA_W-1:0] merged;
  logic [WAIT_W-1:0] unused_wait;

  assign unused_wait = bus.iMC_wait;

  assign req_idx   = bus.iSLB_pc[IDX_W+1:2];
  assign req_tag   = bus.iSLB_pc[ADDR_W-1:IDX_W+2];
  assign req_off   = bus.iSLB_pc[1:0];
  assign line      = data_q[req_idx];
  assign cacheable = bus.iSLB_pc < IO_BASE;
  assign hit       = cacheable & valid_q[req_idx] & (tag_q[req_idx] == req_tag);

  // Byte lanes: len_be selects bytes of the right-aligned value, wr_be places them in the line.
  always_comb begin
    case (bus.iSLB_len)
      LEN_W'(1): len_be = 4'b0001;
      LEN_W'(2): len_be = 4'b0011;
      default:   len_be = 4'b1111;
    endcase
    wr_be    = len_be << req_off;
    rd_shift = line >> {req_off, 3'b000};
    wr_shift = bus.iSLB_dt << {req_off, 3'b000};
    rd_data  = '0;
    merged   = line;
    for (int b = 0; b < 4; b++) begin
      if (len_be[b]) rd_data[8*b +: 8] = rd_shift[8*b +: 8];
      if (wr_be[b])  merged[8*b +: 8]  = wr_shift[8*b +: 8];
    end
  end

  assign bus.oSLB_en = bus.rdy & ~rst & (state_q == S_IDLE);
  assign accept      = bus.iSLB_en & bus.oSLB_en;
  assign go_resp     = accept & ~bus.iSLB_ls & hit;
  assign go_mc       = accept & ~go_resp;
  assign mc_finish   = (state_q == S_WAIT) & bus.iMC_done;
  assign fill_we     = mc_finish & fill_q;
  assign store_we    = accept & bus.iSLB_ls & hit;
  assign fill_idx    = mc_pc_q[IDX_W+1:2];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (go_resp)    state_d = S_RESP;
        else if (go_mc) state_d = S_WAIT;
      end
      S_WAIT:  if (bus.iMC_done) state_d = S_IDLE;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)          state_q <= S_IDLE;
    else if (bus.rdy) state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      mc_en_q    <= 1'b0;
      mc_ls_q    <= 1'b0;
      mc_pc_q    <= '0;
      mc_dt_q    <= '0;
      mc_len_q   <= '0;
      done_q     <= 1'b0;
      slb_dt_q   <= '0;
      slb_nick_q <= '0;
      nick_q     <= '0;
      fill_q     <= 1'b0;
    end else if (bus.rdy) begin
      mc_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (go_resp) begin
        done_q     <= 1'b1;
        slb_dt_q   <= rd_data;
        slb_nick_q <= bus.iSLB_nick;
      end
      if (go_mc) begin
        mc_en_q  <= 1'b1;
        mc_ls_q  <= bus.iSLB_ls;
        mc_pc_q  <= bus.iSLB_pc;
        mc_dt_q  <= bus.iSLB_dt;
        mc_len_q <= bus.iSLB_len;
        nick_q   <= bus.iSLB_nick;
        // Only whole aligned words may allocate; sub-word misses would leave a partial line.
        fill_q   <= ~bus.iSLB_ls & cacheable & (bus.iSLB_len == LEN_W'(4)) & (req_off == 2'b00);
      end
      if (mc_finish) begin
        done_q     <= 1'b1;
        slb_dt_q   <= mc_ls_q ? '0 : bus.iMC_dt;
        slb_nick_q <= nick_q;
      end
      if (fill_we) valid_q[fill_idx] <= 1'b1;
      // An invalidate while the miss is in flight makes the returning data unsafe to keep.
      if ((state_q == S_WAIT) && bus.iInv) fill_q <= 1'b0;
      if (bus.iInv) valid_q <= '0;
    end
  end

  // Fill and store-hit merge never coincide: fills happen in WAIT, merges at acceptance in IDLE.
  always_ff @(posedge clk) begin
    if (!rst && bus.rdy) begin
      if (fill_we) begin
        data_q[fill_idx] <= bus.iMC_dt;
        tag_q[fill_idx]  <= mc_pc_q[ADDR_W-1:IDX_W+2];
      end else if (store_we) begin
        data_q[req_idx] <= merged;
      end
    end
  end

  assign bus.oMC_en    = mc_en_q;
  assign bus.oMC_ls    = mc_ls_q;
  assign bus.oMC_pc    = mc_pc_q;
  assign bus.oMC_dt    = mc_dt_q;
  assign bus.oMC_len   = mc_len_q;
  assign bus.oSLB_done = done_q;
  assign bus.oSLB_dt   = slb_dt_q;
  assign bus.oSLB_nick = slb_nick_q;

endmodule

// File: tb/tb_dcache_dm.sv
// tb/tb_dcache_dm.sv - Self-checking bench for dcache_dm: directed scenarios plus random traffic against a word-level cache model
module tb_dcache_dm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_dm_if bus ();
  dcache_dm dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Backing memory, word addressed; cache model holds full word addresses per line.
  logic [31:0] mem [logic [29:0]];
  logic        mv  [16];
  logic [29:0] mwa [16];
  logic [31:0] md  [16];

  int          r_mc, r_lat, r_done;
  logic [31:0] r_dt, r_mpc, r_mdt;
  logic [3:0]  r_nick;
  logic        r_mls;
  logic [2:0]  r_mlen;

  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] w, input logic [1:0] off,
                                              input logic [2:0] len, input logic [31:0] dt);
    logic [31:0] r;
    r = w;
    for (int b = 0; b < int'(len); b++) r[8*(int'(off)+b) +: 8] = dt[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [2:0] len);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < int'(len); b++) r[8*b +: 8] = w[8*(int'(off)+b) +: 8];
    return r;
  endfunction

  // Issues one request and plays the memory controller; records what the DUT did into r_*.
  task automatic do_req(input logic ls, input logic [31:0] pc, input logic [31:0] dt,
                        input logic [2:0] len, input logic [3:0] nick, input int dly,
                        input logic inv_wait);
    int due;
    int guard;
    r_mc = 0; r_lat = -1; r_done = 0; r_dt = 'x; r_nick = 'x;
    r_mls = 'x; r_mpc = 'x; r_mdt = 'x; r_mlen = 'x;
    due = -1; guard = 0;
    while (bus.oSLB_en !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.iSLB_en = 1'b1; bus.iSLB_ls = ls; bus.iSLB_pc = pc;
    bus.iSLB_dt = dt; bus.iSLB_len = len; bus.iSLB_nick = nick;
    @(negedge clk);
    bus.iSLB_en = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      bus.iMC_done = 1'b0;
      bus.iInv     = 1'b0;
      if (bus.oMC_en === 1'b1) begin
        if (r_mc == 0) begin
          r_mls = bus.oMC_ls; r_mpc = bus.oMC_pc; r_mdt = bus.oMC_dt; r_mlen = bus.oMC_len;
        end
        r_mc++;
        due = c + dly;
      end
      if (bus.oSLB_done === 1'b1) begin
        r_done++;
        if (r_lat < 0) begin
          r_lat = c; r_dt = bus.oSLB_dt; r_nick = bus.oSLB_nick;
        end
      end
      if (c == 1 && inv_wait) bus.iInv = 1'b1;
      if (c == due) begin
        bus.iMC_done = 1'b1;
        if (ls) begin
          bus.iMC_dt = $urandom;
          mem[pc[31:2]] = merge_bytes(mem_rd(pc[31:2]), pc[1:0], len, dt);
        end else begin
          bus.iMC_dt = mem_rd(pc[31:2]);
        end
      end
      if (r_lat >= 0 && c >= r_lat + 1) break;
      @(negedge clk);
    end
    bus.iMC_done = 1'b0;
    bus.iInv     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.oSLB_en !== 1'b0) begin n_fail++; $display("FAIL reset_slb_en got %b want 0", bus.oSLB_en); end
    n_tests++; if (bus.oMC_en !== 1'b0 || bus.oMC_ls !== 1'b0 || bus.oMC_pc !== 32'h0 || bus.oMC_dt !== 32'h0 || bus.oMC_len !== 3'h0) begin
      n_fail++; $display("FAIL reset_mc got en=%b ls=%b pc=%h dt=%h len=%0d want all 0", bus.oMC_en, bus.oMC_ls, bus.oMC_pc, bus.oMC_dt, bus.oMC_len);
    end
    n_tests++; if (bus.oSLB_done !== 1'b0 || bus.oSLB_dt !== 32'h0 || bus.oSLB_nick !== 4'h0) begin
      n_fail++; $display("FAIL reset_slb got done=%b dt=%h nick=%h want all 0", bus.oSLB_done, bus.oSLB_dt, bus.oSLB_nick);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.oSLB_en !== 1'b1) begin n_fail++; $display("FAIL post_reset_slb_en got %b want 1", bus.oSLB_en); end
    bus.rdy = 1'b0;
    #1;
    n_tests++; if (bus.oSLB_en !== 1'b0) begin n_fail++; $display("FAIL rdy_low_slb_en got %b want 0", bus.oSLB_en); end
    bus.rdy = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cold_load();
    mem[30'h40] = 32'hDEADBEEF;
    do_req(1'b0, 32'h100, 32'h0, 3'd4, 4'd3, 2, 1'b0);
    n_tests++; if (r_mc !== 1) begin n_fail++; $display("FAIL cold_mc_pulses got %0d want 1", r_mc); end
    n_tests++; if (r_mls !== 1'b0 || r_mpc !== 32'h100 || r_mlen !== 3'd4) begin
      n_fail++; $display("FAIL cold_mc_req got ls=%b pc=%h len=%0d want 0/100/4", r_mls, r_mpc, r_mlen);
    end
    n_tests++; if (r_lat !== 4 || r_done !== 1) begin n_fail++; $display("FAIL cold_done got lat=%0d cnt=%0d want 4/1", r_lat, r_done); end
    n_tests++; if (r_dt !== 32'hDEADBEEF || r_nick !== 4'd3) begin
      n_fail++; $display("FAIL cold_data got dt=%h nick=%0d want deadbeef/3", r_dt, r_nick);
    end
    do_req(1'b0, 32'h100, 32'h0, 3'd4, 4'd3, 2, 1'b0);
    n_tests++; if (r_mc !== 0 || r_lat !== 1 || r_done !== 1) begin
      n_fail++; $display("FAIL repeat_hit got mc=%0d lat=%0d cnt=%0d want 0/1/1", r_mc, r_lat, r_done);
    end
    n_tests++; if (r_dt !== 32'hDEADBEEF) begin n_fail++; $display("FAIL repeat_hit_dt got %h want deadbeef", r_dt); end
  endtask

  task automatic test_byte_hit();
    do_req(1'b0, 32'h102, 32'hFFFF_FFFF, 3'd1, 4'd5, 1, 1'b0);
    n_tests++; if (r_mc !== 0 || r_lat !== 1) begin n_fail++; $display("FAIL byte_hit got mc=%0d lat=%0d want 0/1", r_mc, r_lat); end
    n_tests++; if (r_dt !== 32'h000000AD || r_nick !== 4'd5) begin
      n_fail++; $display("FAIL byte_hit_dt got dt=%h nick=%0d want 000000ad/5", r_dt, r_nick);
    end
  endtask

  task automatic test_store_half();
    do_req(1'b1, 32'h100, 32'hABCD1234, 3'd2, 4'd6, 1, 1'b0);
    n_tests++; if (r_mc !== 1 || r_mls !== 1'b1 || r_mlen !== 3'd2 || r_mpc !== 32'h100 || r_mdt !== 32'hABCD1234) begin
      n_fail++; $display("FAIL store_mc got n=%0d ls=%b len=%0d pc=%h dt=%h want 1/1/2/100/abcd1234", r_mc, r_mls, r_mlen, r_mpc, r_mdt);
    end
    n_tests++; if (r_lat !== 3 || r_dt !== 32'h0 || r_nick !== 4'd6) begin
      n_fail++; $display("FAIL store_done got lat=%0d dt=%h nick=%0d want 3/0/6", r_lat, r_dt, r_nick);
    end
    do_req(1'b0, 32'h100, 32'h0, 3'd4, 4'd7, 1, 1'b0);
    n_tests++; if (r_mc !== 0 || r_lat !== 1 || r_dt !== 32'hDEAD1234) begin
      n_fail++; $display("FAIL store_then_load got mc=%0d lat=%0d dt=%h want 0/1/dead1234", r_mc, r_lat, r_dt);
    end
  endtask

  task automatic test_uncacheable();
    mem[30'h0C000] = 32'hCAFEF00D;
    for (int k = 0; k < 2; k++) begin
      do_req(1'b0, 32'h30000, 32'h0, 3'd4, 4'(8 + k), k, 1'b0);
      n_tests++; if (r_mc !== 1 || r_lat !== k + 2 || r_dt !== 32'hCAFEF00D || r_nick !== 4'(8 + k)) begin
        n_fail++; $display("FAIL io_load%0d got mc=%0d lat=%0d dt=%h nick=%0d want 1/%0d/cafef00d/%0d", k, r_mc, r_lat, r_dt, r_nick, k + 2, 8 + k);
      end
    end
  endtask

  task automatic test_inv();
    logic [31:0] w140;
    bus.iInv = 1'b1;
    @(negedge clk);
    bus.iInv = 1'b0;
    do_req(1'b0, 32'h100, 32'h0, 3'd4, 4'd1, 1, 1'b0);
    n_tests++; if (r_mc !== 1 || r_dt !== 32'hDEAD1234) begin
      n_fail++; $display("FAIL inv_miss got mc=%0d dt=%h want 1/dead1234", r_mc, r_dt);
    end
    w140 = mem_rd(30'h50);
    do_req(1'b0, 32'h140, 32'h0, 3'd4, 4'd2, 2, 1'b1);
    n_tests++; if (r_done !== 1 || r_dt !== w140 || r_nick !== 4'd2) begin
      n_fail++; $display("FAIL inv_wait_resp got cnt=%0d dt=%h nick=%0d want 1/%h/2", r_done, r_dt, r_nick, w140);
    end
    do_req(1'b0, 32'h140, 32'h0, 3'd4, 4'd3, 0, 1'b0);
    n_tests++; if (r_mc !== 1 || r_dt !== w140) begin
      n_fail++; $display("FAIL inv_wait_nofill got mc=%0d dt=%h want 1/%h", r_mc, r_dt, w140);
    end
  endtask

  task automatic test_reset_in_wait();
    int guard;
    guard = 0;
    while (bus.oSLB_en !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    bus.iSLB_en = 1'b1; bus.iSLB_ls = 1'b0; bus.iSLB_pc = 32'h200; bus.iSLB_len = 3'd4; bus.iSLB_nick = 4'd9;
    @(negedge clk);
    bus.iSLB_en = 1'b0;
    n_tests++; if (bus.oMC_en !== 1'b1) begin n_fail++; $display("FAIL rw_issue got oMC_en=%b want 1", bus.oMC_en); end
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.oMC_en !== 1'b0 || bus.oMC_pc !== 32'h0 || bus.oSLB_done !== 1'b0 || bus.oSLB_en !== 1'b0) begin
      n_fail++; $display("FAIL rw_reset got mc_en=%b pc=%h done=%b slb_en=%b want 0/0/0/0", bus.oMC_en, bus.oMC_pc, bus.oSLB_done, bus.oSLB_en);
    end
    rst = 1'b0;
    bus.iMC_done = 1'b1; bus.iMC_dt = 32'h12345678;
    @(negedge clk);
    bus.iMC_done = 1'b0;
    n_tests++; if (bus.oSLB_done !== 1'b0 || bus.oSLB_en !== 1'b1) begin
      n_fail++; $display("FAIL rw_after got done=%b slb_en=%b want 0/1", bus.oSLB_done, bus.oSLB_en);
    end
    @(negedge clk);
    n_tests++; if (bus.oSLB_done !== 1'b0) begin n_fail++; $display("FAIL rw_late_done got %b want 0", bus.oSLB_done); end
    do_req(1'b0, 32'h200, 32'h0, 3'd4, 4'd4, 0, 1'b0);
    n_tests++; if (r_mc !== 1) begin n_fail++; $display("FAIL rw_no_fill got mc=%0d want 1", r_mc); end
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    // the load just issued fills line 0
    mv[0] = 1'b1; mwa[0] = 30'h80; md[0] = mem_rd(30'h80);
  endtask

  task automatic test_random();
    logic        ls, invw, hit_e;
    logic [2:0]  len;
    logic [1:0]  off;
    logic [29:0] wa;
    logic [31:0] pc, dt, word, exp_dt;
    logic [3:0]  nick, idx;
    int          dly, exp_lat;
    for (int it = 0; it < 80; it++) begin
      ls = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 2))
        0:       begin len = 3'd1; off = 2'($urandom_range(0, 3)); end
        1:       begin len = 3'd2; off = {1'($urandom_range(0, 1)), 1'b0}; end
        default: begin len = 3'd4; off = 2'd0; end
      endcase
      if ($urandom_range(0, 7) == 0) wa = 30'h0C000 + 30'($urandom_range(0, 3));
      else                           wa = 30'($urandom_range(0, 63));
      pc   = {wa, off};
      dt   = $urandom;
      nick = 4'($urandom);
      dly  = $urandom_range(0, 3);
      invw = ($urandom_range(0, 7) == 0);
      idx  = pc[5:2];
      hit_e = (pc < 32'h30000) && mv[idx] && (mwa[idx] == wa);
      word  = mem_rd(wa);
      exp_lat = (hit_e && !ls) ? 1 : dly + 2;
      exp_dt  = ls ? 32'h0 : (hit_e ? extract(md[idx], off, len) : word);
      do_req(ls, pc, dt, len, nick, dly, invw);
      n_tests++; if (r_done !== 1 || r_lat !== exp_lat) begin
        n_fail++; $display("FAIL rnd_done it=%0d got cnt=%0d lat=%0d want 1/%0d", it, r_done, r_lat, exp_lat);
      end
      n_tests++; if (r_dt !== exp_dt || r_nick !== nick) begin
        n_fail++; $display("FAIL rnd_data it=%0d pc=%h got dt=%h nick=%0d want %h/%0d", it, pc, r_dt, r_nick, exp_dt, nick);
      end
      n_tests++; if (r_mc !== ((hit_e && !ls) ? 0 : 1)) begin
        n_fail++; $display("FAIL rnd_mc_pulses it=%0d pc=%h got %0d want %0d", it, pc, r_mc, (hit_e && !ls) ? 0 : 1);
      end
      if (!(hit_e && !ls)) begin
        n_tests++; if (r_mls !== ls || r_mpc !== pc || r_mlen !== len || (ls && r_mdt !== dt)) begin
          n_fail++; $display("FAIL rnd_mc_req it=%0d got ls=%b pc=%h len=%0d dt=%h want %b/%h/%0d/%h", it, r_mls, r_mpc, r_mlen, r_mdt, ls, pc, len, dt);
        end
      end
      if (!ls && !hit_e && pc < 32'h30000 && len == 3'd4 && !invw) begin
        mv[idx] = 1'b1; mwa[idx] = wa; md[idx] = word;
      end
      if (ls && hit_e) md[idx] = merge_bytes(md[idx], off, len, dt);
      if (invw) for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.rdy = 1'b1; bus.iMC_wait = '0; bus.iMC_done = 1'b0; bus.iMC_dt = '0;
    bus.iSLB_en = 1'b0; bus.iSLB_ls = 1'b0; bus.iSLB_pc = '0; bus.iSLB_dt = '0;
    bus.iSLB_len = 3'd4; bus.iSLB_nick = '0; bus.iInv = 1'b0;
    @(negedge clk);
    test_reset();
    test_cold_load();
    test_byte_hit();
    test_store_half();
    test_uncacheable();
    test_inv();
    test_reset_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
